// File: rtl/multi_debounce.sv
// N-channel push-button/switch debouncer: 2-FF synchroniser, per-channel stability counter,
// debounced level plus one-cycle rise/fall pulses. Optional repeat pulses via `AUTOREPEAT_EN.
module multi_debounce #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned STABLE_CNT = 500000,
    parameter int unsigned RST_LEVEL  = 0,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [N_CH-1:0]  RST_VEC  = {N_CH{1'(RST_LEVEL)}};

    logic [N_CH-1:0]  r_s1;
    logic [N_CH-1:0]  r_s2;
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  w_diff;
    logic [N_CH-1:0]  w_done;
    logic [N_CH-1:0]  w_rep_pulse;

    assign w_diff = r_s2 ^ btn_lvl;

    // A channel accepts its new level on the STABLE_CNT-th consecutive differing sample
    always_comb begin
        w_done = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_done[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= RST_VEC;
            r_s2     <= RST_VEC;
            btn_lvl  <= RST_VEC;
            btn_rise <= '0;
            btn_fall <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (w_done[i]) begin
                    btn_lvl[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else if (w_diff[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= '0;
                end
                btn_rise[i] <= (w_done[i] && r_s2[i]) || w_rep_pulse[i];
                btn_fall[i] <= w_done[i] && !r_s2[i];
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned      REP_MAX   = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned      REP_W     = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] r_rep [N_CH];
    logic [N_CH-1:0]  r_rep_first;

    // Repeat fires while held high; suppressed on the cycle a release is accepted
    always_comb begin
        w_rep_pulse = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_rep_pulse[i] = btn_lvl[i] && !w_done[i] &&
                             (r_rep[i] == (r_rep_first[i] ? REP_FIRST : REP_NEXT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_first <= '1;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_rep[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (!btn_lvl[i] || w_done[i]) begin
                    r_rep[i]       <= '0;
                    r_rep_first[i] <= 1'b1;
                end else if (w_rep_pulse[i]) begin
                    r_rep[i]       <= '0;
                    r_rep_first[i] <= 1'b0;
                end else begin
                    r_rep[i] <= r_rep[i] + REP_W'(1);
                end
            end
        end
    end
`else
    localparam int unsigned unused_rep = REP_DELAY ^ REP_PERIOD;

    assign w_rep_pulse = '0;
`endif

endmodule
